// File: rtl/btn_toggle_pulse.sv
// btn_toggle_pulse: debounces a raw asynchronous push-button and emits a
// single-cycle toggle pulse per accepted press for a downstream T flip-flop.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   btn_in     in   raw button level (asynchronous, may bounce)
//   t          out  registered one-cycle toggle pulse
//   btn_level  out  registered debounced button level
//
// Parameters:
//   STABLE_CYCLES  consecutive synchronized samples needed to accept a change (2..65535)
//   REPEAT_CYCLES  auto-repeat period in clocks (2..2^24-1), used only with AUTO_REPEAT_EN
//
// Build option:
//   AUTO_REPEAT_EN  when defined, a held button re-fires t every REPEAT_CYCLES clocks.
module btn_toggle_pulse #(
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned REPEAT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic t,
   output logic btn_level
);

   localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_e;

   state_e          state_q;
   logic            s1_q;
   logic            s_q;
   logic [CntW-1:0] cnt_q;
   logic            t_q;
   logic            level_q;
   logic [CntW-1:0] cnt_inc_c;

`ifdef AUTO_REPEAT_EN
   localparam int unsigned RepW = 24;
   localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);
   logic [RepW-1:0] rep_q;
`else
   // Repeat period has no effect in this build.
   if (REPEAT_CYCLES < 2) begin : g_repeat_unused
   end
`endif

   // Saturating increment; the counter never wraps back to zero.
   assign cnt_inc_c = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

   // Synchronizer, debounce FSM and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s_q     <= 1'b0;
         cnt_q   <= '0;
         state_q <= IDLE;
         t_q     <= 1'b0;
         level_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
         rep_q   <= '0;
`endif
      end else begin
         s1_q <= btn_in;
         s_q  <= s1_q;
         t_q  <= 1'b0;

         case (state_q)
            IDLE: begin
               if (s_q) begin
                  state_q <= PRESS_WAIT;
                  cnt_q   <= CntW'(1);
               end
            end
            PRESS_WAIT: begin
               if (!s_q) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CntLast) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
                  t_q     <= 1'b1;
                  level_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_inc_c;
               end
            end
            PRESSED: begin
               if (!s_q) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= CntW'(1);
               end
            end
            RELEASE_WAIT: begin
               if (s_q) begin
                  // Release bounce: back to pressed without a new pulse.
                  state_q <= PRESSED;
                  cnt_q   <= '0;
               end else if (cnt_q == CntLast) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  level_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_inc_c;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               level_q <= 1'b0;
            end
         endcase

`ifdef AUTO_REPEAT_EN
         // Repeat timer runs only while settled in PRESSED; any other state restarts it.
         if (state_q == PRESSED) begin
            if (rep_q == RepLast) begin
               rep_q <= '0;
               t_q   <= 1'b1;
            end else begin
               rep_q <= rep_q + RepW'(1);
            end
         end else begin
            rep_q <= '0;
         end
`endif
      end
   end

   assign t         = t_q;
   assign btn_level = level_q;

endmodule

// File: tb/tb_btn_toggle_pulse.sv
// tb_btn_toggle_pulse: directed and random stimulus for btn_toggle_pulse,
// checked against a run-length debounce model and a T flip-flop chain.
module tb_btn_toggle_pulse;

   localparam int SC = 4;
   localparam int RC = 8;
`ifdef AUTO_REPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic btn_in;
   logic t;
   logic btn_level;
   logic q;

   int tests = 0;
   int fails = 0;

   // Reference model state: two-stage sample delay, accepted level, run of
   // disagreeing samples, cycles spent settled-pressed, expected pulse and q.
   bit m_s1, m_s, m_level, m_t, m_q;
   int m_run, m_hold;

   always #10 clk = ~clk;

   btn_toggle_pulse #(
      .STABLE_CYCLES(SC),
      .REPEAT_CYCLES(RC)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in),
      .t        (t),
      .btn_level(btn_level)
   );

   // Downstream T flip-flop fed by the pulse.
   always_ff @(posedge clk) begin
      if (rst) q <= 1'b0;
      else if (t) q <= ~q;
   end

   task automatic check(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   // Level flips once STABLE consecutive samples disagree with it; a pulse is
   // issued on a flip to 1, and optionally every RC cycles of settled hold.
   task automatic model_edge(input logic r, input logic b);
      bit settled;
      if (r) begin
         m_s1 = 0; m_s = 0; m_level = 0; m_run = 0; m_hold = 0; m_t = 0; m_q = 0;
      end else begin
         if (m_t) m_q = ~m_q;
         settled = m_level && (m_run == 0);
         m_t = 0;
         if (m_s != m_level) m_run++;
         else m_run = 0;
         if (m_run == SC) begin
            m_level = ~m_level;
            m_run = 0;
            if (m_level) m_t = 1;
         end
         if (AR) begin
            if (settled) begin
               m_hold++;
               if (m_hold == RC) begin
                  m_t = 1;
                  m_hold = 0;
               end
            end else begin
               m_hold = 0;
            end
         end
         m_s = m_s1;
         m_s1 = b;
      end
   endtask

   // One clock: drive on falling edge, update model at rising edge, sample 1 ns later.
   task automatic step(input logic b, input logic r);
      @(negedge clk);
      btn_in = b;
      rst = r;
      @(posedge clk);
      model_edge(r, b);
      #1;
      check("model_t", t, m_t);
      check("model_level", btn_level, m_level);
      check("model_q", q, m_q);
   endtask

   initial begin
      int len;
      logic v, r;
      rst = 1'b1;
      btn_in = 1'b0;

      // Reset state
      step(0, 1);
      step(0, 1);
      check("reset_t", t, 1'b0);
      check("reset_level", btn_level, 1'b0);
      step(0, 0);
      step(0, 0);

      // Clean press: pulse only after edge 5, level from edge 5
      for (int k = 0; k < 10; k++) begin
         step(1, 0);
         check("clean_t", t, k == 5);
         check("clean_level", btn_level, k >= 5);
      end
      // Clean release: level falls 5 edges after first low sample, no pulse
      for (int k = 0; k < 8; k++) begin
         step(0, 0);
         check("release_t", t, 1'b0);
         check("release_level", btn_level, k < 5);
      end

      // Press bounce 1,1,0,1,0,1 then high: one pulse 5 edges after last rise (index 5)
      for (int k = 0; k < 15; k++) begin
         logic [5:0] pat;
         pat = 6'b101011;
         step((k < 6) ? pat[k] : 1'b1, 0);
         check("pbounce_t", t, k == 10);
      end

      // Release bounce 0,0,1,0 then low: level falls 5 edges after index 3
      for (int k = 0; k < 12; k++) begin
         logic [3:0] pat;
         pat = 4'b0100;
         step((k < 4) ? pat[k] : 1'b0, 0);
         check("rbounce_t", t, 1'b0);
         check("rbounce_level", btn_level, k < 8);
      end

      // Reset mid-debounce: cnt reaches 3 after edge 4, then reset with button held
      for (int k = 0; k < 5; k++) step(1, 0);
      step(1, 1);
      check("midrst_t", t, 1'b0);
      check("midrst_level", btn_level, 1'b0);
      step(1, 1);
      check("midrst_t2", t, 1'b0);
      check("midrst_level2", btn_level, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step(1, 0);
         check("postrst_t", t, k == 5);
      end
      for (int k = 0; k < 8; k++) step(0, 0);

      // Chain: three presses toggle q 0->1->0->1
      step(0, 1);
      step(0, 1);
      check("chain_q0", q, 1'b0);
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 8; k++) step(1, 0);
         check("chain_q", q, logic'((p + 1) % 2));
         for (int k = 0; k < 8; k++) step(0, 0);
      end

      // Hold: repeats at +8,+16,+24 after the press pulse only with AUTO_REPEAT_EN
      for (int k = 0; k < 33; k++) begin
         step(1, 0);
         check("hold_t", t, (k == 5) || (AR && (k == 13 || k == 21 || k == 29)));
      end
      for (int k = 0; k < 10; k++) begin
         step(0, 0);
         check("hold_release_t", t, 1'b0);
      end

      // Random runs of levels with occasional reset
      for (int i = 0; i < 300; i++) begin
         v = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 9));
         r = ($urandom_range(0, 39) == 0);
         for (int j = 0; j < len; j++) step(v, r && (j < 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
